axis_decimator: RTL and testbench
=================================

Name: axis_decimator

Overview:
- Downstream of the microphone FIR low-pass stage, upstream of the FFT.
- Accepts the filtered AXI-Stream sample stream, keeps one sample in every DECIM, and rounds/saturates it from IN_W to OUT_W bits.
- Emits an AXI-Stream with tlast marking every FRAME_LEN output samples, so the FFT receives framed blocks.
- Default settings take 48 kHz to 6 kHz.

Parameters:
- IN_W, 32: input sample width, signed two's complement.
- OUT_W, 24: output sample width, signed. Must be less than IN_W.
- DECIM, 8: decimation factor. Must be at least 1; 1 means pass-through.
- FRAME_LEN, 1024: output samples per frame (the FFT point count). Must be at least 2.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous active-low reset.
- clear_in  input  1  synchronous restart of phase and frame counters plus buffer flush; active-high for 1 cycle.
- s_axis_tvalid  input  1  FIR output valid.
- s_axis_tready  output  1  ready to FIR.
- s_axis_tdata  input  IN_W  filtered sample.
- m_axis_tvalid  output  1  decimated sample valid.
- m_axis_tready  input  1  FFT ready.
- m_axis_tdata  output  OUT_W  decimated, rounded sample.
- m_axis_tlast  output  1  last sample of frame.
- frame_done_out  output  1  1-cycle pulse when a tlast beat is transferred.

Behaviour:
Reset (rst_in low, asynchronous):
- m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, frame_done_out=0, s_axis_tready=0.
- Phase counter=0, frame counter=0, buffer empty.
- s_axis_tready rises on the first clk_in edge after rst_in deasserts.

Input handshake:
- A beat is accepted when s_axis_tvalid and s_axis_tready are both high.
- s_axis_tready is driven from a register only (no combinational path from m_axis_tready). It equals "skid slot empty".

Phase counter:
- Range 0..DECIM-1. Increments on every accepted beat and wraps from DECIM-1 to 0.
- The beat accepted while phase==0 is kept; all other beats are accepted and discarded.
- The first beat after reset or clear is therefore kept.

Arithmetic on kept beats:
- SH = IN_W-OUT_W.
- sum = tdata + 2^(SH-1), computed in IN_W+1 bits (round half up).
- Result = sum[IN_W-1:SH].
- If sum overflows positive (positive input, sign flips), the result is 2^(OUT_W-1)-1.
- Negative inputs never saturate.

Frame counter:
- Range 0..FRAME_LEN-1. Advances when a kept sample is pushed into the buffer, not at output transfer.
- The pushed sample carries tlast=1 when the counter equals FRAME_LEN-1; the counter then wraps to 0.

Output buffer:
- 2-entry skid buffer holding {data, last}.
- Latency: a kept beat accepted at edge N is visible on m_axis at edge N+1 when the buffer is empty.
- m_axis_tvalid stays high, and m_axis_tdata/tlast stay stable, until m_axis_tready.
- With m_axis_tready held high: full throughput of 1 beat per cycle, no bubbles.
- Buffer full (skid occupied): s_axis_tready=0. Backpressure propagates to the FIR.
- Discarded beats stall too while s_axis_tready=0, so the phase alignment is preserved.

frame_done_out:
- Registered. Pulses the cycle after an m_axis transfer with tlast=1.

clear_in:
- Next edge: phase=0, frame=0, buffer emptied, m_axis_tvalid=0.
- Takes priority over a simultaneous input accept (that beat is dropped) and over an output transfer (frame_done_out suppressed).
- A partial frame is abandoned and is not padded.

Reset mid-frame: everything returns to the reset state; no partial-frame tlast is produced.

Decomposition:
- mic_pkg holds MIC_IN_W=32, MIC_OUT_W=24, MIC_DECIM=8, MIC_FFT_LEN=1024, and the function round_sat(IN_W, OUT_W) as a constant function.
- Sub-module axis_skid_buffer (parameter W): a 2-entry registered-ready buffer, instantiated with W=OUT_W+1 for data plus last.
- Phase/frame counters and rounding stay in axis_decimator.

Test Plan:
- Ramp pass-through: DECIM=8, inputs 0,256,512,... (value k*256) with m_axis_tready=1 -> outputs 0,8,16,... at OUT_W=24, one per 8 inputs. The first output appears 1 cycle after input 0 is accepted.
- Rounding/saturation: inputs 0x0000007F, 0x00000080, 0xFFFFFF80, 0x7FFFFFFF, 0x80000000 (DECIM=1) -> outputs 0x000000, 0x000001, 0x000000, 0x7FFFFF, 0x800000.
- Framing: DECIM=2, FRAME_LEN=4, feed 16 inputs -> 8 outputs; tlast on outputs 4 and 8; frame_done_out pulses twice, each 1 cycle after the tlast transfer.
- Backpressure: m_axis_tready=0 for 10 cycles with constant s_axis_tvalid -> s_axis_tready falls once 2 kept samples are buffered. On release, no sample is lost or duplicated, and order plus phase match a no-stall reference model.
- clear_in mid-frame: FRAME_LEN=4, clear after 2 outputs, simultaneous with an input accept -> the accepted beat is dropped, the next input is kept, and the next tlast lands on the 4th output after clear.
- Async reset: assert rst_in low mid-stream between clock edges -> m_axis_tvalid=0 immediately. After release, the first input is kept and the frame count restarts at 0.

Source files
------------

// File: rtl/mic_pkg.sv
// Shared constants and arithmetic helpers for the microphone decimation path.
package mic_pkg;

    localparam int MIC_IN_W    = 32;
    localparam int MIC_OUT_W   = 24;
    localparam int MIC_DECIM   = 8;
    localparam int MIC_FFT_LEN = 1024;

    // Round half up from in_w to out_w bits and clamp positive overflow.
    // Operates on a sign-extended 64-bit value so one function serves any width pair;
    // the caller keeps the low out_w bits. Negative inputs can never exceed the range.
    function automatic logic signed [63:0] round_sat(
        input logic signed [63:0] x,
        input int                 in_w,
        input int                 out_w
    );
        logic signed [63:0] half_v;
        logic signed [63:0] sum_v;
        logic signed [63:0] res_v;
        logic signed [63:0] max_v;
        half_v = 64'sd1 <<< (in_w - out_w - 1);
        sum_v  = x + half_v;
        res_v  = sum_v >>> (in_w - out_w);
        max_v  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        if (res_v > max_v) begin
            res_v = max_v;
        end else begin
            res_v = res_v;
        end
        return res_v;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream buffer whose input ready comes straight from a register.
// ready is high exactly when the skid slot is empty, so upstream never sees m_ready.
module axis_skid_buffer #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    logic         main_valid_r;
    logic [W-1:0] main_data_r;
    logic         skid_valid_r;
    logic [W-1:0] skid_data_r;
    logic         ready_r;

    logic         push_s;
    logic         pop_s;
    logic         main_valid_s;
    logic [W-1:0] main_data_s;
    logic         skid_valid_s;
    logic [W-1:0] skid_data_s;

    // Next-state for the output slot and the skid slot.
    always_comb begin
        push_s       = s_valid & ready_r;
        pop_s        = main_valid_r & m_ready;
        main_valid_s = main_valid_r;
        main_data_s  = main_data_r;
        skid_valid_s = skid_valid_r;
        skid_data_s  = skid_data_r;
        if (pop_s || !main_valid_r) begin
            if (skid_valid_r) begin
                // Skid occupied means ready was low, so no push can coincide.
                main_valid_s = 1'b1;
                main_data_s  = skid_data_r;
                skid_valid_s = 1'b0;
            end else begin
                main_valid_s = push_s;
                main_data_s  = push_s ? s_data : main_data_r;
            end
        end else begin
            if (push_s) begin
                skid_valid_s = 1'b1;
                skid_data_s  = s_data;
            end else begin
                skid_valid_s = skid_valid_r;
                skid_data_s  = skid_data_r;
            end
        end
    end

    // Storage registers; clr empties both slots and reopens the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_r <= 1'b0;
            main_data_r  <= {W{1'b0}};
            skid_valid_r <= 1'b0;
            skid_data_r  <= {W{1'b0}};
            ready_r      <= 1'b0;
        end else if (clr) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            ready_r      <= 1'b1;
        end else begin
            main_valid_r <= main_valid_s;
            main_data_r  <= main_data_s;
            skid_valid_r <= skid_valid_s;
            skid_data_r  <= skid_data_s;
            ready_r      <= ~skid_valid_s;
        end
    end

    assign s_ready = ready_r;
    assign m_valid = main_valid_r;
    assign m_data  = main_data_r;

endmodule

// File: rtl/axis_decimator.sv
// Keeps one sample in every DECIM, rounds/saturates it to OUT_W bits and frames the
// output stream with tlast every FRAME_LEN samples for the downstream FFT.
module axis_decimator
    import mic_pkg::*;
#(
    parameter int IN_W      = MIC_IN_W,
    parameter int OUT_W     = MIC_OUT_W,
    parameter int DECIM     = MIC_DECIM,
    parameter int FRAME_LEN = MIC_FFT_LEN
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clear_in,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [IN_W-1:0]  s_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [OUT_W-1:0] m_axis_tdata,
    output logic             m_axis_tlast,
    output logic             frame_done_out
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int FR_W = $clog2(FRAME_LEN);

    logic [PH_W-1:0]  phase_r;
    logic [FR_W-1:0]  frame_r;
    logic             frame_done_r;

    logic             ready_s;
    logic             accept_s;
    logic             keep_s;
    logic             push_s;
    logic             last_s;
    logic [OUT_W-1:0] rounded_s;
    logic [OUT_W:0]   buf_in_s;
    logic [OUT_W:0]   buf_out_s;
    logic             buf_valid_s;

    // Handshake decode, rounding of the incoming sample and the tlast flag it would carry.
    always_comb begin
        accept_s  = s_axis_tvalid & ready_s;
        keep_s    = (phase_r == PH_W'(0));
        push_s    = accept_s & keep_s & ~clear_in;
        last_s    = (frame_r == FR_W'(FRAME_LEN - 1));
        rounded_s = OUT_W'(round_sat({{(64 - IN_W){s_axis_tdata[IN_W-1]}}, s_axis_tdata},
                                     IN_W, OUT_W));
        buf_in_s  = {rounded_s, last_s};
    end

    // Phase counter: advances on every accepted beat, kept or discarded.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            phase_r <= PH_W'(0);
        end else if (clear_in) begin
            phase_r <= PH_W'(0);
        end else if (accept_s) begin
            if (phase_r == PH_W'(DECIM - 1)) begin
                phase_r <= PH_W'(0);
            end else begin
                phase_r <= phase_r + PH_W'(1);
            end
        end else begin
            phase_r <= phase_r;
        end
    end

    // Frame counter: advances when a kept sample enters the buffer, not at output.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            frame_r <= FR_W'(0);
        end else if (clear_in) begin
            frame_r <= FR_W'(0);
        end else if (push_s) begin
            if (last_s) begin
                frame_r <= FR_W'(0);
            end else begin
                frame_r <= frame_r + FR_W'(1);
            end
        end else begin
            frame_r <= frame_r;
        end
    end

    // One-cycle pulse after a tlast beat leaves; a coinciding clear suppresses it.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            frame_done_r <= 1'b0;
        end else if (clear_in) begin
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= buf_valid_s & m_axis_tready & buf_out_s[0];
        end
    end

    // Discarded beats still need ready, so only kept beats are offered to the buffer.
    axis_skid_buffer #(
        .W (OUT_W + 1)
    ) u_skid (
        .clk     (clk_in),
        .rst_n   (rst_in),
        .clr     (clear_in),
        .s_valid (s_axis_tvalid & keep_s),
        .s_ready (ready_s),
        .s_data  (buf_in_s),
        .m_valid (buf_valid_s),
        .m_ready (m_axis_tready),
        .m_data  (buf_out_s)
    );

    assign s_axis_tready  = ready_s;
    assign m_axis_tvalid  = buf_valid_s;
    assign m_axis_tdata   = buf_out_s[OUT_W:1];
    assign m_axis_tlast   = buf_out_s[0];
    assign frame_done_out = frame_done_r;

endmodule

// File: tb/tb_axis_decimator.sv
// Bench for axis_decimator: two instances (DECIM=8 and DECIM=2, both FRAME_LEN=4)
// checked every cycle against a queue-based model plus literal expectations.
module tb_axis_decimator;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [1:0]  clear_in, s_valid, s_ready, m_valid, m_ready, m_last, fdone;
    logic [31:0] s_data [2];
    logic [23:0] m_data [2];

    always #5 clk = ~clk;

    axis_decimator #(.IN_W(32), .OUT_W(24), .DECIM(8), .FRAME_LEN(4)) dut0 (
        .clk_in(clk), .rst_in(rst_in), .clear_in(clear_in[0]),
        .s_axis_tvalid(s_valid[0]), .s_axis_tready(s_ready[0]), .s_axis_tdata(s_data[0]),
        .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready[0]), .m_axis_tdata(m_data[0]),
        .m_axis_tlast(m_last[0]), .frame_done_out(fdone[0]));

    axis_decimator #(.IN_W(32), .OUT_W(24), .DECIM(2), .FRAME_LEN(4)) dut1 (
        .clk_in(clk), .rst_in(rst_in), .clear_in(clear_in[1]),
        .s_axis_tvalid(s_valid[1]), .s_axis_tready(s_ready[1]), .s_axis_tdata(s_data[1]),
        .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready[1]), .m_axis_tdata(m_data[1]),
        .m_axis_tlast(m_last[1]), .frame_done_out(fdone[1]));

    localparam int FLEN = 4;
    int          dec [2] = '{8, 2};

    // Model state: expected buffer contents as a ring of {data, last}.
    logic [24:0] exp_q [2][0:15];
    int          head [2], tail [2], n_acc [2], n_kept [2];
    bit          started [2], fd_exp [2];
    // Log of actual DUT transfers and frame_done pulses, for literal checks.
    logic [23:0] log_d [2][0:255];
    bit          log_l [2][0:255];
    int          log_n [2], fd_cnt [2];

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rounding: nearest integer of x/256, halves upward, clamp to max positive.
    function automatic logic [23:0] ref_round(input logic [31:0] x);
        real r;
        r = $floor($itor($signed(x)) / 256.0 + 0.5);
        if (r > 8388607.0) r = 8388607.0;
        return 24'($rtoi(r));
    endfunction

    // Called on each falling edge: compare outputs, then apply what the next rising edge does.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int          sz;
            bit          exp_rdy, xfer, acc;
            logic [24:0] front;
            sz    = tail[i] - head[i];
            front = exp_q[i][head[i] % 16];
            if (!rst_in) begin
                chk($sformatf("rst_m_tvalid[%0d]", i), m_valid[i], 0);
                chk($sformatf("rst_s_tready[%0d]", i), s_ready[i], 0);
                chk($sformatf("rst_m_tdata[%0d]", i), m_data[i], 0);
                chk($sformatf("rst_m_tlast[%0d]", i), m_last[i], 0);
                chk($sformatf("rst_frame_done[%0d]", i), fdone[i], 0);
                head[i] = 0; tail[i] = 0; n_acc[i] = 0; n_kept[i] = 0;
                started[i] = 1'b0; fd_exp[i] = 1'b0;
            end else begin
                exp_rdy = started[i] && (sz < 2);
                chk($sformatf("m_tvalid[%0d]", i), m_valid[i], sz > 0);
                chk($sformatf("s_tready[%0d]", i), s_ready[i], exp_rdy);
                chk($sformatf("frame_done[%0d]", i), fdone[i], fd_exp[i]);
                if (sz > 0) begin
                    chk($sformatf("m_tdata[%0d]", i), m_data[i], front[24:1]);
                    chk($sformatf("m_tlast[%0d]", i), m_last[i], front[0]);
                end
                if (fdone[i]) fd_cnt[i]++;
                xfer = (sz > 0) && m_ready[i];
                acc  = s_valid[i] && exp_rdy;
                fd_exp[i] = xfer && front[0] && !clear_in[i];
                if (clear_in[i]) begin
                    head[i] = tail[i]; n_acc[i] = 0; n_kept[i] = 0;
                end else begin
                    if (m_valid[i] && m_ready[i]) begin
                        log_d[i][log_n[i] % 256] = m_data[i];
                        log_l[i][log_n[i] % 256] = m_last[i];
                        log_n[i]++;
                    end
                    if (xfer) head[i]++;
                    if (acc) begin
                        if (n_acc[i] % dec[i] == 0) begin
                            exp_q[i][tail[i] % 16] = {ref_round(s_data[i]), (n_kept[i] % FLEN) == FLEN - 1};
                            tail[i]++;
                            n_kept[i]++;
                        end
                        n_acc[i]++;
                    end
                end
                started[i] = 1'b1;
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input int i, input logic [31:0] x);
        bit rdy;
        s_valid[i] = 1'b1;
        s_data[i]  = x;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            rdy = s_ready[i];
            @(posedge clk); #1;
            if (rdy) break;
            if (t == 199) begin
                n_checks++; n_errs++;
                $display("FAIL send_timeout[%0d]: got no accept expected accept", i);
            end
        end
        s_valid[i] = 1'b0;
    endtask

    // Random traffic: valid with probability pv%, m_ready with pr%; data held until accepted.
    task automatic stream(input int i, input int ncyc, input int pv, input int pr);
        bit took;
        took = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (took || !s_valid[i]) begin
                s_valid[i] = ($urandom_range(99) < pv);
                s_data[i]  = $urandom;
            end
            m_ready[i] = ($urandom_range(99) < pr);
            @(negedge clk);
            took = s_valid[i] && s_ready[i];
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_log(input string nm, input int i, input int idx,
                           input logic [23:0] d, input bit l);
        chk($sformatf("%s_data[%0d]", nm, idx), log_d[i][idx % 256], d);
        chk($sformatf("%s_last[%0d]", nm, idx), log_l[i][idx % 256], l);
    endtask

    initial begin
        int b, f;
        logic [31:0] rv [5];
        logic [23:0] ro [5];
        logic [23:0] co [6];
        rst_in = 1'b0; clear_in = 2'b00; s_valid = 2'b00; m_ready = 2'b11;
        s_data[0] = 32'h0; s_data[1] = 32'h0;
        fork
            forever begin @(negedge clk); model_step(); end
        join_none

        // Pin the reference rounding to hand-computed values.
        chk("ref_round_7f", ref_round(32'h0000007F), 24'h000000);
        chk("ref_round_80", ref_round(32'h00000080), 24'h000001);
        chk("ref_round_ff80", ref_round(32'hFFFFFF80), 24'h000000);
        chk("ref_round_max", ref_round(32'h7FFFFFFF), 24'h7FFFFF);
        chk("ref_round_min", ref_round(32'h80000000), 24'h800000);

        cyc(3);
        rst_in = 1'b1;
        cyc(2);

        // Ramp through DECIM=8: input k*256 -> output k for every 8th k.
        b = log_n[0];
        for (int k = 0; k < 32; k++) send(0, 32'(k * 256));
        cyc(3);
        chk("ramp_count", log_n[0] - b, 4);
        for (int j = 0; j < 4; j++) chk_log("ramp", 0, b + j, 24'(j * 8), j == 3);

        // Rounding corners on DECIM=2, each followed by a discarded filler.
        rv = '{32'h0000007F, 32'h00000080, 32'hFFFFFF80, 32'h7FFFFFFF, 32'h80000000};
        ro = '{24'h000000, 24'h000001, 24'h000000, 24'h7FFFFF, 24'h800000};
        b = log_n[1];
        for (int j = 0; j < 5; j++) begin send(1, rv[j]); send(1, 32'h12345678); end
        cyc(3);
        chk("round_count", log_n[1] - b, 5);
        for (int j = 0; j < 5; j++) chk_log("round", 1, b + j, ro[j], j == 3);

        // Framing: clear, then 16 inputs -> 8 outputs, tlast on the 4th and 8th.
        clear_in[1] = 1'b1; cyc(1); clear_in[1] = 1'b0;
        b = log_n[1]; f = fd_cnt[1];
        for (int k = 0; k < 16; k++) send(1, 32'(k * 512));
        cyc(3);
        chk("frame_count", log_n[1] - b, 8);
        for (int j = 0; j < 8; j++) chk_log("frame", 1, b + j, 24'(j * 4), (j % 4) == 3);
        chk("frame_done_pulses", fd_cnt[1] - f, 2);

        // clear_in mid-frame coinciding with an accept of a would-be-kept beat.
        b = log_n[1]; f = fd_cnt[1];
        send(1, 32'h100); send(1, 32'h200); send(1, 32'h300); send(1, 32'h400);
        s_valid[1] = 1'b1; s_data[1] = 32'h900; clear_in[1] = 1'b1;
        cyc(1);
        clear_in[1] = 1'b0;
        send(1, 32'h500); send(1, 32'h600); send(1, 32'h700); send(1, 32'h800);
        send(1, 32'hA00); send(1, 32'hB00); send(1, 32'hC00); send(1, 32'hD00);
        cyc(3);
        co = '{24'd1, 24'd3, 24'd5, 24'd7, 24'd10, 24'd12};
        chk("clear_count", log_n[1] - b, 6);
        for (int j = 0; j < 6; j++) chk_log("clear", 1, b + j, co[j], j == 5);
        chk("clear_frame_done", fd_cnt[1] - f, 1);

        // Backpressure: downstream stalled, upstream always valid.
        b = log_n[0];
        stream(0, 20, 100, 0);
        chk("bp_s_tready", s_ready[0], 0);
        chk("bp_m_tvalid", m_valid[0], 1);
        chk("bp_no_output", log_n[0] - b, 0);
        stream(0, 60, 70, 100);

        // Random traffic on both instances.
        fork
            stream(0, 400, 60, 60);
            stream(1, 400, 80, 50);
        join
        s_valid = 2'b00; m_ready = 2'b11;
        cyc(4);

        // Asynchronous reset mid-stream, between clock edges.
        stream(0, 20, 100, 0);
        @(posedge clk); #3;
        rst_in = 1'b0; s_valid = 2'b00;
        #1;
        chk("async_m_tvalid", m_valid[0], 0);
        chk("async_s_tready", s_ready[0], 0);
        cyc(2);
        rst_in = 1'b1; m_ready = 2'b11;
        cyc(1);
        b = log_n[0]; f = fd_cnt[0];
        for (int k = 0; k < 32; k++) send(0, 32'((k + 16) * 256));
        cyc(3);
        chk("post_rst_count", log_n[0] - b, 4);
        for (int j = 0; j < 4; j++) chk_log("post_rst", 0, b + j, 24'(16 + j * 8), j == 3);
        chk("post_rst_frame_done", fd_cnt[0] - f, 1);

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
